// File: rtl/uart_mem_bridge.sv
// UART byte-frame parser driving memory write/read strobes; read data is
// returned to the UART transmitter over a valid/ready handshake.
module uart_mem_bridge #(
  parameter int         DATA_BYTES = 2,
  parameter int         ADDR_W     = 8,
  parameter int         RD_LAT     = 1,
  parameter int         TIMEOUT    = 50000,
  parameter logic [3:0] OP_WRITE   = 4'h6,
  parameter logic [3:0] OP_READ    = 4'h7
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    data_rdy,
  input  logic [7:0]              data_in,
  output logic                    write_enable,
  output logic                    read_enable,
  output logic [ADDR_W-1:0]       addr,
  output logic [8*DATA_BYTES-1:0] data_out,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    frame_err,
  output logic                    busy
);
  localparam int DW = 8*DATA_BYTES;
  localparam int AB = (ADDR_W+7)/8;
  localparam int TW = $clog2(TIMEOUT+1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RD_REQ  = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_SEND    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     shr_q, shr_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [2:0]        lat_q, lat_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              ferr_q, ferr_d;
  logic              rdy_q, bp_q;
  logic              tmo_hit;
  logic [ADDR_W+7:0] addr_sh;
  logic [DW+7:0]     data_sh;

  assign addr_sh = {addr_q, data_in};
  assign data_sh = {data_q, data_in};
  assign tmo_hit = (tmo_q == TW'(TIMEOUT));

  // Previous-value register resets high so a level already present at
  // reset release is not mistaken for a new byte.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b1;
      bp_q  <= 1'b0;
    end else begin
      rdy_q <= data_rdy;
      bp_q  <= data_rdy & ~rdy_q;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    shr_d   = shr_q;
    bcnt_d  = bcnt_q;
    lat_d   = lat_q;
    tmo_d   = tmo_q;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        tmo_d  = '0;
        if (bp_q) begin
          if (data_in[7:4] == OP_WRITE || data_in[7:4] == OP_READ) begin
            op_d    = data_in[7:4];
            state_d = S_ADDR;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        // Timeout outranks a byte arriving in the same cycle.
        if (tmo_hit) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (bp_q) begin
          tmo_d = '0;
          if (state_q == S_ADDR) addr_d = addr_sh[ADDR_W-1:0];
          else                   data_d = data_sh[DW-1:0];
          if (state_q == S_ADDR && bcnt_q == 3'(AB-1)) begin
            bcnt_d  = '0;
            state_d = (op_q == OP_WRITE) ? S_DATA : S_RD_REQ;
          end else if (state_q == S_DATA && bcnt_q == 3'(DATA_BYTES-1)) begin
            bcnt_d  = '0;
            state_d = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_RD_REQ: begin
        lat_d   = 3'd1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == 3'(RD_LAT)) begin
          shr_d   = rd_data;
          bcnt_d  = '0;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          shr_d = shr_q << 8;
          if (bcnt_q == 3'(DATA_BYTES-1)) state_d = S_IDLE;
          else                            bcnt_d  = bcnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      shr_q   <= '0;
      bcnt_q  <= '0;
      lat_q   <= '0;
      tmo_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shr_q   <= shr_d;
      bcnt_q  <= bcnt_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
      ferr_q  <= ferr_d;
    end
  end

  assign write_enable = (state_q == S_WRITE);
  assign read_enable  = (state_q == S_RD_REQ);
  assign addr         = addr_q;
  assign data_out     = data_q;
  assign tx_data      = shr_q[DW-1 -: 8];
  assign tx_valid     = (state_q == S_SEND);
  assign frame_err    = ferr_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
Parametrised successor to the UART-addressed memory controller. Parses byte frames from the UART receiver into memory write and read transactions, with configurable data-word width, address width and read latency. Read data is returned to the UART transmitter through a valid/ready handshake, and malformed or stalled frames are aborted. Sits between uart_rx/uart_tx and the register/memory bank.

Parameters:
DATA_BYTES, 2, bytes per data word; data_out and rd_data are 8*DATA_BYTES wide; legal range 1..4.
ADDR_W, 8, address width; legal range 1..16; ADDR_BYTES = ceil(ADDR_W/8).
RD_LAT, 1, cycles from the read_enable cycle to the rd_data capture cycle; legal range 1..4.
TIMEOUT, 50000, idle clk_in cycles allowed between bytes inside a frame before the frame is aborted.
OP_WRITE, 4'h6, header opcode for a write frame.
OP_READ, 4'h7, header opcode for a read frame.

Ports:
clk_in  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
data_rdy  in  1  UART rx byte-ready level; rising edge marks a new byte.
data_in  in  8  UART rx byte; stable while data_rdy is high.
write_enable  out  1  one-cycle memory write strobe.
read_enable  out  1  one-cycle memory read strobe.
addr  out  ADDR_W  transaction address.
data_out  out  8*DATA_BYTES  write data.
rd_data  in  8*DATA_BYTES  memory read data.
tx_data  out  8  byte to uart_tx.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  uart_tx can accept a byte.
frame_err  out  1  one-cycle pulse when a frame is aborted.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset is asynchronous, so asserting it mid-frame or mid-send drops the transaction immediately and leaves no pending strobe.
- Byte pulse: the edge-detector previous-value register resets to 1, so a data_rdy already high at reset release is not a byte. A byte pulse (bp) is high for the single cycle after each data_rdy rising edge. data_in is sampled in the bp cycle.
- Frame format: header byte (opcode in [7:4], [3:0] reserved and ignored), then ADDR_BYTES address bytes MSB first. Address bits above ADDR_W are discarded.
  - Write frame: followed by DATA_BYTES data bytes, MSB first.
  - Read frame: has no further bytes.
- State IDLE:
  - bp with opcode OP_WRITE or OP_READ: latch the opcode and go to ADDR.
  - bp with any other opcode: frame_err pulses the next cycle; stay in IDLE.
- State ADDR: shift each bp byte into addr.
  - After the last address byte: OP_WRITE goes to DATA; OP_READ goes to RD_REQ.
- State DATA: shift each bp byte into data_out (MSB first). After the last data byte go to WRITE.
- State WRITE: write_enable=1 for exactly one cycle, then IDLE. write_enable rises on the cycle after the final data byte's bp.
- State RD_REQ: read_enable=1 for one cycle (cycle T). Go to RD_WAIT.
- State RD_WAIT: capture rd_data into a shift register at the end of cycle T+RD_LAT, then go to SEND.
- State SEND: present bytes MSB first on tx_data with tx_valid=1.
  - A byte transfers on a cycle where tx_valid and tx_ready are both high.
  - tx_data and tx_valid stay stable while tx_ready is low.
  - After DATA_BYTES transfers, tx_valid drops and the state returns to IDLE.
- Timeout: the counter clears on every bp and increments each cycle in ADDR and DATA. When it reaches TIMEOUT, pulse frame_err, go to IDLE, and leave addr/data_out unchanged from the partial frame. No strobe is issued. There is no timeout in RD_WAIT or SEND; SEND waits on tx_ready indefinitely.
- Bytes arriving in WRITE, RD_REQ, RD_WAIT or SEND are dropped silently (no frame_err). rx/tx are half-duplex at the protocol level.
- A bp in the same cycle that a timeout fires is dropped; the timeout wins.
- addr and data_out hold their values between frames.

Test Plan:
- Write, defaults: bytes 0x60,0x2A,0xBE,0xEF -> write_enable high exactly 1 cycle, addr=0x2A, data_out=0xBEEF at the strobe, busy low afterwards.
- Read: bytes 0x70,0x2A; memory model returns 0x1234 one cycle after read_enable; tx_ready held low for 5 cycles then high -> tx_data 0x12 then 0x34, each transferred exactly once, tx_data stable during the stall.
- Timeout: TIMEOUT=100; send 0x60,0x05, then no byte for 100 cycles -> one frame_err pulse, no write_enable, state IDLE. A following complete write frame 0x60,0x01,0x00,0x07 succeeds.
- Bad opcode and dropped bytes: 0x9F -> frame_err pulse, stays IDLE. A byte 0x60 sent during SEND is ignored; the next frame parses normally.
- Reset mid-frame: reset asserted after 0x60,0x2A,0xBE -> all outputs 0 asynchronously. After release with data_rdy held high, no spurious byte is detected.
- Parameter variant DATA_BYTES=4, ADDR_W=12, RD_LAT=3: write 0x60,0x0A,0xBC,0xDE,0xAD,0xBE,0xEF -> addr=0xABC, data_out=0xDEADBEEF. A read returns 4 bytes, with rd_data captured 3 cycles after read_enable.
